// File: rtl/cpu_ctrl_pkg.sv
// Encodings shared by the hardwired control sequencer and its datapath.
// Latency: n/a (constants, types and one pure helper function).
// Backpressure: n/a.
package cpu_ctrl_pkg;

  // Instruction opcodes, ir[31:27]
  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_SHR  = 5'b00111;
  localparam logic [4:0] OP_SHL  = 5'b01000;
  localparam logic [4:0] OP_ROR  = 5'b01001;
  localparam logic [4:0] OP_ROL  = 5'b01010;
  localparam logic [4:0] OP_ADDI = 5'b01011;
  localparam logic [4:0] OP_ANDI = 5'b01100;
  localparam logic [4:0] OP_ORI  = 5'b01101;
  localparam logic [4:0] OP_MUL  = 5'b01110;
  localparam logic [4:0] OP_DIV  = 5'b01111;
  localparam logic [4:0] OP_NEG  = 5'b10000;
  localparam logic [4:0] OP_NOT  = 5'b10001;
  localparam logic [4:0] OP_IN   = 5'b10110;
  localparam logic [4:0] OP_OUT  = 5'b10111;
  localparam logic [4:0] OP_MFHI = 5'b11000;
  localparam logic [4:0] OP_MFLO = 5'b11001;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  // ALU ops equal the instruction opcode; INC computes B+1 for the PC
  localparam logic [4:0] ALU_INC = 5'b11111;

  // Bus source select bit positions (0..15 are the GPRs)
  localparam logic [4:0] BUS_HI     = 5'd16;
  localparam logic [4:0] BUS_LO     = 5'd17;
  localparam logic [4:0] BUS_ZHI    = 5'd18;
  localparam logic [4:0] BUS_ZLO    = 5'd19;
  localparam logic [4:0] BUS_PC     = 5'd20;
  localparam logic [4:0] BUS_MDR    = 5'd21;
  localparam logic [4:0] BUS_INPORT = 5'd22;
  localparam logic [4:0] BUS_C      = 5'd23;

  typedef enum logic [2:0] {
    S_F0, S_F1, S_F2, S_F3, S_EX, S_EW, S_HALT
  } state_t;

  // Immediate forms reuse the register-form ALU op; ldi is an add to Rb
  function automatic logic [4:0] imm_alu_op(input logic [4:0] op);
    case (op)
      OP_ANDI: return OP_AND;
      OP_ORI:  return OP_OR;
      default: return OP_ADD;
    endcase
  endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// Control bundle between the sequencer (master) and the datapath (slave).
// Latency: wires only.
// Backpressure: memory stalls are carried by mem_ready; no other flow control.
interface control_sequencer_if;
  logic [31:0] ir;
  logic        mem_ready;
  logic [15:0] gpr_in;
  logic        IRin, PCin, RYin, RZin, MARin, MDRin, HIin, LOin, Outport_in, Inport_in;
  logic [23:0] Bus_Encoder_signals;
  logic        Mem_read;
  logic        mem_req;
  logic        mem_write;
  logic [4:0]  opcode;
  logic        run;
  logic        illegal;

  modport master (
    input  ir, mem_ready,
    output gpr_in, IRin, PCin, RYin, RZin, MARin, MDRin, HIin, LOin, Outport_in, Inport_in,
           Bus_Encoder_signals, Mem_read, mem_req, mem_write, opcode, run, illegal
  );

  modport slave (
    output ir, mem_ready,
    input  gpr_in, IRin, PCin, RYin, RZin, MARin, MDRin, HIin, LOin, Outport_in, Inport_in,
           Bus_Encoder_signals, Mem_read, mem_req, mem_write, opcode, run, illegal
  );
endinterface

// File: rtl/control_sequencer.sv
// Hardwired fetch/execute sequencer driving datapath strobes, bus select and ALU op.
// Latency: outputs are combinational from state, step counter and ir; state moves each edge.
// Backpressure: F2 and EW hold until mem_ready; every other state ignores mem_ready.
module control_sequencer
  import cpu_ctrl_pkg::*;
(
  input  logic                clock,
  input  logic                clear,
  control_sequencer_if.master bus
);

  state_t     state, state_nxt;
  logic [2:0] t, t_nxt;
  logic       last;
  logic [4:0] op;
  logic [3:0] ra, rb, rc;

  assign op = bus.ir[31:27];
  assign ra = bus.ir[26:23];
  assign rb = bus.ir[22:19];
  assign rc = bus.ir[18:15];

  // Low IR bits carry immediates consumed by the datapath, not by control
  wire unused_ir = &{1'b0, bus.ir[14:0]};

  // State and step counter; clear forces a fresh fetch from any state
  always_ff @(posedge clock) begin
    if (!clear) begin
      state <= S_F0;
      t     <= '0;
    end else begin
      state <= state_nxt;
      t     <= t_nxt;
    end
  end

  // Next-state and output decode; everything is held at zero while clear is low
  always_comb begin
    state_nxt               = state;
    t_nxt                   = t;
    last                    = 1'b0;
    bus.gpr_in              = '0;
    bus.IRin                = 1'b0;
    bus.PCin                = 1'b0;
    bus.RYin                = 1'b0;
    bus.RZin                = 1'b0;
    bus.MARin               = 1'b0;
    bus.MDRin               = 1'b0;
    bus.HIin                = 1'b0;
    bus.LOin                = 1'b0;
    bus.Outport_in          = 1'b0;
    bus.Inport_in           = 1'b0;
    bus.Bus_Encoder_signals = '0;
    bus.Mem_read            = 1'b0;
    bus.mem_req             = 1'b0;
    bus.mem_write           = 1'b0;
    bus.opcode              = '0;
    bus.run                 = 1'b0;
    bus.illegal             = 1'b0;

    if (clear) begin
      bus.run = (state != S_HALT);
      case (state)
        S_F0: begin
          bus.Bus_Encoder_signals[BUS_PC] = 1'b1;
          bus.MARin  = 1'b1;
          bus.opcode = ALU_INC;
          bus.RZin   = 1'b1;
          state_nxt  = S_F1;
        end
        S_F1: begin
          bus.Bus_Encoder_signals[BUS_ZLO] = 1'b1;
          bus.PCin  = 1'b1;
          state_nxt = S_F2;
        end
        S_F2: begin
          bus.mem_req  = 1'b1;
          bus.Mem_read = 1'b1;
          bus.MDRin    = bus.mem_ready;
          if (bus.mem_ready) state_nxt = S_F3;
        end
        S_F3: begin
          bus.Bus_Encoder_signals[BUS_MDR] = 1'b1;
          bus.IRin  = 1'b1;
          state_nxt = S_EX;
          t_nxt     = '0;
        end
        S_EX: begin
          t_nxt = t + 3'd1;
          case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHL, OP_ROR, OP_ROL,
            OP_ADDI, OP_ANDI, OP_ORI, OP_LDI: begin
              case (t)
                3'd0: begin bus.Bus_Encoder_signals[{1'b0, rb}] = 1'b1; bus.RYin = 1'b1; end
                3'd1: begin
                  if (op >= OP_ADD && op <= OP_ROL) begin
                    bus.Bus_Encoder_signals[{1'b0, rc}] = 1'b1;
                    bus.opcode = op;
                  end else begin
                    bus.Bus_Encoder_signals[BUS_C] = 1'b1;
                    bus.opcode = imm_alu_op(op);
                  end
                  bus.RZin = 1'b1;
                end
                default: begin bus.Bus_Encoder_signals[BUS_ZLO] = 1'b1; bus.gpr_in[ra] = 1'b1; last = 1'b1; end
              endcase
            end
            OP_NEG, OP_NOT: begin
              if (t == 3'd0) begin
                bus.Bus_Encoder_signals[{1'b0, rb}] = 1'b1;
                bus.opcode = op;
                bus.RZin   = 1'b1;
              end else begin
                bus.Bus_Encoder_signals[BUS_ZLO] = 1'b1;
                bus.gpr_in[ra] = 1'b1;
                last = 1'b1;
              end
            end
            OP_MUL, OP_DIV: begin
              case (t)
                3'd0: begin bus.Bus_Encoder_signals[{1'b0, ra}] = 1'b1; bus.RYin = 1'b1; end
                3'd1: begin bus.Bus_Encoder_signals[{1'b0, rb}] = 1'b1; bus.opcode = op; bus.RZin = 1'b1; end
                3'd2: begin bus.Bus_Encoder_signals[BUS_ZLO] = 1'b1; bus.LOin = 1'b1; end
                default: begin bus.Bus_Encoder_signals[BUS_ZHI] = 1'b1; bus.HIin = 1'b1; last = 1'b1; end
              endcase
            end
            OP_LD, OP_ST: begin
              // ld enters the memory wait after address setup, st after loading MDR
              case (t)
                3'd0: begin bus.Bus_Encoder_signals[{1'b0, rb}] = 1'b1; bus.RYin = 1'b1; end
                3'd1: begin bus.Bus_Encoder_signals[BUS_C] = 1'b1; bus.opcode = OP_ADD; bus.RZin = 1'b1; end
                3'd2: begin
                  bus.Bus_Encoder_signals[BUS_ZLO] = 1'b1;
                  bus.MARin = 1'b1;
                  if (op == OP_LD) state_nxt = S_EW;
                end
                3'd3: begin
                  bus.Bus_Encoder_signals[{1'b0, ra}] = 1'b1;
                  bus.MDRin = 1'b1;
                  state_nxt = S_EW;
                end
                default: begin bus.Bus_Encoder_signals[BUS_MDR] = 1'b1; bus.gpr_in[ra] = 1'b1; last = 1'b1; end
              endcase
            end
            OP_IN: begin
              if (t == 3'd0) bus.Inport_in = 1'b1;
              else begin
                bus.Bus_Encoder_signals[BUS_INPORT] = 1'b1;
                bus.gpr_in[ra] = 1'b1;
                last = 1'b1;
              end
            end
            OP_OUT: begin
              bus.Bus_Encoder_signals[{1'b0, ra}] = 1'b1;
              bus.Outport_in = 1'b1;
              last = 1'b1;
            end
            OP_MFHI: begin bus.Bus_Encoder_signals[BUS_HI] = 1'b1; bus.gpr_in[ra] = 1'b1; last = 1'b1; end
            OP_MFLO: begin bus.Bus_Encoder_signals[BUS_LO] = 1'b1; bus.gpr_in[ra] = 1'b1; last = 1'b1; end
            OP_NOP:  last = 1'b1;
            OP_HALT: state_nxt = S_HALT;
            default: begin bus.illegal = 1'b1; last = 1'b1; end
          endcase
          if (last) begin
            state_nxt = S_F0;
            t_nxt     = '0;
          end
        end
        S_EW: begin
          bus.mem_req = 1'b1;
          if (op == OP_LD) begin
            bus.Mem_read = 1'b1;
            bus.MDRin    = bus.mem_ready;
          end else begin
            bus.mem_write = 1'b1;
          end
          if (bus.mem_ready) begin
            if (op == OP_LD) begin
              state_nxt = S_EX;
              t_nxt     = 3'd4;
            end else begin
              state_nxt = S_F0;
              t_nxt     = '0;
            end
          end
        end
        S_HALT: state_nxt = S_HALT;
        default: begin
          state_nxt = S_F0;
          t_nxt     = '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: per-cycle expected output table built from instruction rules.
// Latency: one comparison per clock, sampled 1 ns after the falling edge.
// Backpressure: mem_ready stalls are scripted per instruction; outside wait states it is randomized.
module tb_control_sequencer;

  logic clock;
  logic clear;
  control_sequencer_if ifc();

  control_sequencer dut (
    .clock (clock),
    .clear (clear),
    .bus   (ifc)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  localparam int B_HI = 16, B_LO = 17, B_ZHI = 18, B_ZLO = 19, B_PC = 20, B_MDR = 21, B_INP = 22, B_C = 23;
  localparam logic [9:0] EN_IR  = 10'h200, EN_PC = 10'h100, EN_RY  = 10'h080, EN_RZ  = 10'h040;
  localparam logic [9:0] EN_MAR = 10'h020, EN_MDR = 10'h010, EN_HI = 10'h008, EN_LO  = 10'h004;
  localparam logic [9:0] EN_OUT = 10'h002, EN_INP = 10'h001;

  int n_checks = 0;
  int n_fail   = 0;

  logic [63:0] exp_q[$];
  logic [31:0] ir_q[$];
  logic        rdy_q[$];
  logic        clr_q[$];
  string       tag_q[$];

  logic [31:0] cur_ir;
  string       cur_tag;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [23:0] src(input int idx);
    logic [23:0] v;
    v = '0;
    if (idx >= 0) v = 24'd1 << idx;
    return v;
  endfunction

  function automatic logic [15:0] g1(input int r);
    return 16'd1 << r;
  endfunction

  // Packed view: {pad, gpr_in, enables, bus, Mem_read, mem_req, mem_write, opcode, run, illegal}
  function automatic logic [63:0] vec(input logic [23:0] b, input logic [15:0] g, input logic [9:0] en,
                                      input logic [4:0] op, input logic mrd, input logic mreq,
                                      input logic mwr, input logic rn, input logic ill);
    return {4'b0, g, en, b, mrd, mreq, mwr, op, rn, ill};
  endfunction

  function automatic logic [63:0] obs();
    return vec(ifc.Bus_Encoder_signals, ifc.gpr_in,
               {ifc.IRin, ifc.PCin, ifc.RYin, ifc.RZin, ifc.MARin, ifc.MDRin,
                ifc.HIin, ifc.LOin, ifc.Outport_in, ifc.Inport_in},
               ifc.opcode, ifc.Mem_read, ifc.mem_req, ifc.mem_write, ifc.run, ifc.illegal);
  endfunction

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic push(input logic [63:0] e, input logic rdy, input logic [31:0] irv,
                      input logic clr, input string tag);
    tag_q.push_back($sformatf("%s@%0d", tag, exp_q.size()));
    exp_q.push_back(e);
    rdy_q.push_back(rdy);
    ir_q.push_back(irv);
    clr_q.push_back(clr);
  endtask

  // Ordinary execute step: no memory signals, running, mem_ready don't-care
  task automatic step(input logic [23:0] b, input logic [15:0] g, input logic [9:0] en, input logic [4:0] op);
    push(vec(b, g, en, op, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0), rbit(), cur_ir, 1'b1, cur_tag);
  endtask

  // Fetch: IR still holds stale contents, so drive garbage there
  task automatic plan_fetch(input int fs);
    push(vec(src(B_PC), 0, EN_MAR | EN_RZ, 5'b11111, 0, 0, 0, 1, 0), rbit(), $urandom, 1'b1, "f0");
    push(vec(src(B_ZLO), 0, EN_PC, 0, 0, 0, 0, 1, 0), rbit(), $urandom, 1'b1, "f1");
    for (int k = 0; k < fs; k++)
      push(vec(0, 0, 0, 0, 1, 1, 0, 1, 0), 1'b0, $urandom, 1'b1, "f2_wait");
    push(vec(0, 0, EN_MDR, 0, 1, 1, 0, 1, 0), 1'b1, $urandom, 1'b1, "f2_ready");
    push(vec(src(B_MDR), 0, EN_IR, 0, 0, 0, 0, 1, 0), rbit(), $urandom, 1'b1, "f3");
  endtask

  task automatic plan_exec(input logic [31:0] instr, input int es);
    int op, ra, rb, rc, alu;
    op = int'(instr[31:27]);
    ra = int'(instr[26:23]);
    rb = int'(instr[22:19]);
    rc = int'(instr[18:15]);
    cur_ir  = instr;
    cur_tag = $sformatf("ex_op%02h", op);
    if (op >= 3 && op <= 10) begin
      step(src(rb), 0, EN_RY, 0);
      step(src(rc), 0, EN_RZ, 5'(op));
      step(src(B_ZLO), g1(ra), 0, 0);
    end else if (op == 1 || (op >= 11 && op <= 13)) begin
      alu = (op == 12) ? 5 : (op == 13) ? 6 : 3;
      step(src(rb), 0, EN_RY, 0);
      step(src(B_C), 0, EN_RZ, 5'(alu));
      step(src(B_ZLO), g1(ra), 0, 0);
    end else if (op == 16 || op == 17) begin
      step(src(rb), 0, EN_RZ, 5'(op));
      step(src(B_ZLO), g1(ra), 0, 0);
    end else if (op == 14 || op == 15) begin
      step(src(ra), 0, EN_RY, 0);
      step(src(rb), 0, EN_RZ, 5'(op));
      step(src(B_ZLO), 0, EN_LO, 0);
      step(src(B_ZHI), 0, EN_HI, 0);
    end else if (op == 0 || op == 2) begin
      step(src(rb), 0, EN_RY, 0);
      step(src(B_C), 0, EN_RZ, 5'd3);
      step(src(B_ZLO), 0, EN_MAR, 0);
      if (op == 0) begin
        for (int k = 0; k < es; k++)
          push(vec(0, 0, 0, 0, 1, 1, 0, 1, 0), 1'b0, cur_ir, 1'b1, "ld_wait");
        push(vec(0, 0, EN_MDR, 0, 1, 1, 0, 1, 0), 1'b1, cur_ir, 1'b1, "ld_ready");
        step(src(B_MDR), g1(ra), 0, 0);
      end else begin
        step(src(ra), 0, EN_MDR, 0);
        for (int k = 0; k < es; k++)
          push(vec(0, 0, 0, 0, 0, 1, 1, 1, 0), 1'b0, cur_ir, 1'b1, "st_wait");
        push(vec(0, 0, 0, 0, 0, 1, 1, 1, 0), 1'b1, cur_ir, 1'b1, "st_ready");
      end
    end else if (op == 22) begin
      step(0, 0, EN_INP, 0);
      step(src(B_INP), g1(ra), 0, 0);
    end else if (op == 23) begin
      step(src(ra), 0, EN_OUT, 0);
    end else if (op == 24) begin
      step(src(B_HI), g1(ra), 0, 0);
    end else if (op == 25) begin
      step(src(B_LO), g1(ra), 0, 0);
    end else if (op == 26) begin
      step(0, 0, 0, 0);
    end else if (op == 27) begin
      step(0, 0, 0, 0);
      for (int k = 0; k < 20; k++)
        push(64'd0, rbit(), $urandom, 1'b1, "halted");
    end else begin
      push(vec(0, 0, 0, 0, 0, 0, 0, 1, 1), rbit(), cur_ir, 1'b1, "illegal");
    end
  endtask

  task automatic plan_instr(input logic [31:0] instr, input int fs, input int es);
    plan_fetch(fs);
    plan_exec(instr, es);
  endtask

  task automatic plan_reset(input int n);
    for (int k = 0; k < n; k++)
      push(64'd0, rbit(), $urandom, 1'b0, "reset");
  endtask

  task automatic play();
    while (exp_q.size() > 0) begin
      logic [63:0] e;
      string       tg;
      e  = exp_q.pop_front();
      tg = tag_q.pop_front();
      @(negedge clock);
      clear         = clr_q.pop_front();
      ifc.ir        = ir_q.pop_front();
      ifc.mem_ready = rdy_q.pop_front();
      #1;
      check_eq(tg, obs(), e);
    end
  endtask

  initial begin
    logic [31:0] instr;
    int          op;
    clear         = 1'b0;
    ifc.ir        = '0;
    ifc.mem_ready = 1'b0;

    plan_reset(3);
    // add R3,R1,R2 with no stalls
    plan_instr(32'h1989_0000, 0, 0);
    // ld R5,(R2) with three EW stall cycles
    plan_instr({5'd0, 4'd5, 4'd2, 19'd0}, 1, 3);
    // st R7,(R4) with two EW stall cycles
    plan_instr({5'd2, 4'd7, 4'd4, 19'd0}, 0, 2);
    // clear pulsed during an F2 stall abandons the fetch
    push(vec(src(B_PC), 0, EN_MAR | EN_RZ, 5'b11111, 0, 0, 0, 1, 0), rbit(), $urandom, 1'b1, "f0");
    push(vec(src(B_ZLO), 0, EN_PC, 0, 0, 0, 0, 1, 0), rbit(), $urandom, 1'b1, "f1");
    push(vec(0, 0, 0, 0, 1, 1, 0, 1, 0), 1'b0, $urandom, 1'b1, "f2_wait");
    push(vec(0, 0, 0, 0, 1, 1, 0, 1, 0), 1'b0, $urandom, 1'b1, "f2_wait");
    plan_reset(1);
    // undefined opcode 11100
    plan_instr({5'b11100, 27'($urandom)}, 0, 0);

    for (int n = 0; n < 150; n++) begin
      op = $urandom_range(0, 31);
      if (op == 27) op = 26;
      instr = {5'(op), 27'($urandom)};
      plan_instr(instr, $urandom_range(0, 3), $urandom_range(0, 3));
    end

    plan_instr({5'd27, 27'($urandom)}, 0, 0);
    plan_reset(2);
    plan_instr({5'd26, 27'($urandom)}, 0, 0);

    play();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
